// File: rtl/vote_session_ctrl.sv
// Four-member voting session controller: opens on start, collects one vote per member, classifies yes-count.
// Latency: closing vote at edge K -> DECIDE after K -> result/result_valid/done valid after edge K+1.
// No backpressure: votes are strobes accepted whenever COLLECT is active; done is a single-cycle pulse.
module vote_session_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] vote_valid,
  input  logic [3:0] vote_yes,
  output logic       busy,
  output logic [3:0] voted,
  output logic [2:0] tally,
  output logic [3:1] result,
  output logic       result_valid,
  output logic       done
);

  // Timer only needs to reach TIMEOUT-1; the session closes on that value.
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [3:0]    voted_nxt;
  logic [2:0]    tally_nxt;
  logic [3:1]    result_nxt;
  logic          result_valid_nxt;
  logic          done_nxt;

  // Votes from members who have not yet voted this session; repeats are masked off.
  logic [3:0]    accept;
  logic [2:0]    yes_cnt;

  // Map the final yes-count onto the one-hot majority code.
  function automatic logic [3:1] classify(input logic [2:0] cnt);
    case (cnt)
      3'd0, 3'd1: classify = 3'b001;
      3'd2:       classify = 3'b010;
      default:    classify = 3'b100;
    endcase
  endfunction

  assign busy   = (state != IDLE);
  assign accept = vote_valid & ~voted;

  // Count the yes votes among this cycle's newly accepted members.
  always_comb begin
    yes_cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      yes_cnt = yes_cnt + {2'b00, accept[i] & vote_yes[i]};
    end
  end

  // Next-state and datapath updates; everything holds unless the state says otherwise.
  always_comb begin
    state_nxt        = state;
    timer_nxt        = timer;
    voted_nxt        = voted;
    tally_nxt        = tally;
    result_nxt       = result;
    result_valid_nxt = result_valid;
    done_nxt         = 1'b0;
    case (state)
      IDLE: begin
        // Vote strobes are ignored here; only start matters.
        if (start) begin
          state_nxt        = COLLECT;
          timer_nxt        = '0;
          voted_nxt        = 4'b0000;
          tally_nxt        = 3'd0;
          result_nxt       = 3'b000;
          result_valid_nxt = 1'b0;
        end
      end
      COLLECT: begin
        voted_nxt = voted | accept;
        tally_nxt = tally + yes_cnt;
        // Exit uses the post-update voted set so the closing vote counts;
        // votes landing on the timeout edge are also counted above.
        if (voted_nxt == 4'b1111 || timer == TIMER_LAST) begin
          state_nxt = DECIDE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      DECIDE: begin
        result_nxt       = classify(tally);
        result_valid_nxt = 1'b1;
        done_nxt         = 1'b1;
        state_nxt        = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial session.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      voted        <= 4'b0000;
      tally        <= 3'd0;
      result       <= 3'b000;
      result_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      voted        <= voted_nxt;
      tally        <= tally_nxt;
      result       <= result_nxt;
      result_valid <= result_valid_nxt;
      done         <= done_nxt;
    end
  end

  // Structural invariants of the controller.
  a_done_single : assert property (@(posedge clk) disable iff (rst) done |=> !done);
  a_tally_range : assert property (@(posedge clk) disable iff (rst) tally <= 3'd4);
  a_result_code : assert property (@(posedge clk) disable iff (rst)
                                   (result == 3'b000) || $onehot(result));

endmodule

// File: doc/vote_session_ctrl.md
# vote_session_ctrl

Sequencing controller for the four-member voting datapath. It opens a voting session on command, accepts at most one vote per member, and closes the session when all four have voted or a timeout expires. It then classifies the yes-count into the team's one-hot 3-bit majority code and holds the result until the next session opens. It sits between the members' vote buttons and the result display/consumer logic.

## Interface

- TIMEOUT, 16: session length in clock cycles, counted from the first COLLECT cycle; legal range ≥ 2.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  session-open request; sampled only in IDLE.
- vote_valid  input  4  per-member vote strobe; bit i = member i.
- vote_yes  input  4  per-member vote value (1 = yes); meaningful only where vote_valid[i]=1.
- busy  output  1  high in COLLECT and DECIDE.
- voted  output  4  bit i set once member i's vote is accepted in the current session.
- tally  output  3  live count of accepted yes votes (0..4).
- result  output  3  one-hot outcome, declared as [3:1]: 3'b001 = 0–1 yes, 3'b010 = 2 yes, 3'b100 = 3–4 yes; 3'b000 = no result.
- result_valid  output  1  high while result holds a completed session's outcome.
- done  output  1  one-cycle pulse when result is first published.

## Operation

- States: IDLE, COLLECT, DECIDE.
- IDLE:
  - start=1 → COLLECT.
  - On that same edge: voted←0, tally←0, timer←0, result←000, result_valid←0.
  - vote_valid is ignored in IDLE.
- COLLECT:
  - At each edge, for every i with vote_valid[i]=1 and voted[i]=0: set voted[i] and add vote_yes[i] to tally.
  - Multiple members may vote in the same cycle; all are accepted.
  - A repeat strobe from a member who has already voted is ignored. The first vote wins, and a value change is not accepted.
  - timer increments each COLLECT cycle.
- COLLECT exit, evaluated at the same edge using the post-update voted value:
  - voted becomes 4'b1111 → DECIDE.
  - Otherwise, timer == TIMEOUT-1 → DECIDE. Votes sampled on that edge still count.
  - Members who have not voted count as no.
- DECIDE: exactly one cycle. On the next edge:
  - result ← classify(tally).
  - result_valid ← 1.
  - done ← 1.
  - State → IDLE.
- classify uses the widths and codes from the Interface. Encoding: 0/1 → 001, 2 → 010, 3/4 → 100. tally can never exceed 4, and no other value is produced.
- start during COLLECT or DECIDE is ignored; it does not restart or extend the session.
- result, result_valid, voted and tally hold their values in IDLE until the next accepted start.

## Timing

- Reset values (asynchronous, immediate): state IDLE, busy 0, voted 0000, tally 000, result 000, result_valid 0, done 0, timer 0.
- start sampled high at edge S → busy=1 from S. The first vote can be accepted at edge S+1.
- Session closing:
  - Closing vote accepted at edge K → state DECIDE after K.
  - At edge K+1: result, result_valid and done are valid, and busy=0.
  - At edge K+2: done=0.
- Vote-to-result latency: 2 edges.
- Timeout: with no votes, DECIDE is entered at edge S+TIMEOUT and done is high after S+TIMEOUT+1.
- start held high continuously: a new session opens at the first edge in IDLE, i.e. the edge after done rises. On that same edge done falls and result_valid clears.
- Reset asserted mid-session: everything returns to reset values; no done pulse; the partial session is discarded.
- done is never asserted for two consecutive cycles.

## Test plan

- Reset, then all four members vote at once with vote_yes=1011 → voted=1111, tally=3, then after 2 edges result=100, result_valid=1, done=1 for exactly one cycle.
- Votes arrive over separate cycles: m0 yes, m2 no, m1 yes, m3 no → tally=2, result=010. Repeat strobe from m0 with vote_yes=0 is ignored and tally stays 2.
- TIMEOUT=16, only m1 votes yes → close at S+16, result=001, voted=0010, done after S+17.
- Vote strobes in IDLE and start pulses during COLLECT → no effect on voted, tally or timer, and the session length is unchanged.
- rst asserted mid-COLLECT after 2 votes → all outputs at reset values immediately, no done. A new start gives a clean session with result=000 until completion.
- start held high for three sessions with 0, 2 and 4 yes votes → results 001, 010, 100. Each done is a single-cycle pulse, and result_valid drops on each reopen edge.
